// File: rtl/alu_pkg.sv
// Shared ALU datapath constants.
//   ALU_WIDTH : default operand width of the ALU datapath, in bits.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 8;

endpackage

// File: rtl/unsigned_magnitude_cmp.sv
// Unsigned magnitude comparator, MSB-first ripple.
// Ports:
//   x  : operand X, W bits, unsigned
//   y  : operand Y, W bits, unsigned
//   gt : 1 iff x > y
//   eq : 1 iff x == y
module unsigned_magnitude_cmp
    import alu_pkg::*;
#(
    parameter int unsigned W = ALU_WIDTH - 1
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic         gt,
    output logic         eq
);

    // Walk from the MSB down: the first bit position where the operands
    // differ decides gt; eq survives only if every bit matched.
    always_comb begin
        gt = 1'b0;
        eq = 1'b1;
        for (int unsigned k = 0; k < W; k++) begin
            gt = gt | (eq & x[W-1-k] & ~y[W-1-k]);
            eq = eq & (x[W-1-k] ~^ y[W-1-k]);
        end
    end

endmodule

// File: rtl/signed_comparator.sv
// Registered two's-complement comparator for the ALU flag logic.
// Ports:
//   clk          : rising-edge clock
//   rst          : synchronous active-high reset
//   valid_in     : a/b valid this cycle, compare them
//   a, b         : SIZE-bit two's-complement operands
//   valid_out    : flags hold the result of the previous valid_in cycle
//   is_a_greater : signed(a) > signed(b), held while valid_in is low
//   equal        : a == b bitwise, held while valid_in is low
module signed_comparator
    import alu_pkg::*;
#(
    parameter int unsigned SIZE = ALU_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic            valid_out,
    output logic            is_a_greater,
    output logic            equal
);

    logic mag_gt;
    logic mag_eq;
    logic sign_a;
    logic sign_b;
    logic cmp_gt;
    logic cmp_eq;

    logic valid_q;
    logic gt_q;
    logic gt_d;
    logic eq_q;
    logic eq_d;

    assign sign_a = a[SIZE-1];
    assign sign_b = b[SIZE-1];

    unsigned_magnitude_cmp #(
        .W (SIZE - 1)
    ) u_mag_cmp (
        .x  (a[SIZE-2:0]),
        .y  (b[SIZE-2:0]),
        .gt (mag_gt),
        .eq (mag_eq)
    );

    // Differing signs: the non-negative operand wins. Equal signs: the
    // magnitude bits order the values the same way for both signs.
    always_comb begin
        cmp_eq = mag_eq & (sign_a ~^ sign_b);
        if (sign_a != sign_b) begin
            cmp_gt = ~sign_a;
        end else begin
            cmp_gt = mag_gt;
        end
    end

    // Flags only load on valid_in so the last result persists.
    always_comb begin
        gt_d = valid_in ? cmp_gt : gt_q;
        eq_d = valid_in ? cmp_eq : eq_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            valid_q <= valid_in;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
        end
    end

    assign valid_out    = valid_q;
    assign is_a_greater = gt_q;
    assign equal        = eq_q;

endmodule

// File: tb/tb_signed_comparator.sv
// Self-checking bench for signed_comparator at SIZE=4 and SIZE=8.
module tb_signed_comparator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       v4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       vo4, gt4, eq4;

    logic       v8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       vo8, gt8, eq8;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Scoreboards of expected {gt, eq}
    logic [1:0] q4[$];
    logic [1:0] q8[$];

    // Expected visible output state
    logic mv4 = 1'b0, mg4 = 1'b0, me4 = 1'b0;
    logic mv8 = 1'b0, mg8 = 1'b0, me8 = 1'b0;

    always #5 clk = ~clk;

    signed_comparator #(.SIZE(4)) dut4 (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (v4),
        .a            (a4),
        .b            (b4),
        .valid_out    (vo4),
        .is_a_greater (gt4),
        .equal        (eq4)
    );

    signed_comparator #(.SIZE(8)) dut8 (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (v8),
        .a            (a8),
        .b            (b8),
        .valid_out    (vo8),
        .is_a_greater (gt8),
        .equal        (eq8)
    );

    function automatic logic ref_gt4(input logic [3:0] x, input logic [3:0] y);
        logic signed [3:0] sx;
        logic signed [3:0] sy;
        sx = x;
        sy = y;
        return sx > sy;
    endfunction

    function automatic logic ref_gt8(input logic [7:0] x, input logic [7:0] y);
        logic signed [7:0] sx;
        logic signed [7:0] sy;
        sx = x;
        sy = y;
        return sx > sy;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (a4=%h b4=%h a8=%h b8=%h t=%0t)",
                     tag, got, exp, a4, b4, a8, b8, $time);
        end
    endtask

    // Drive one cycle of stimulus (called at negedge), then check after posedge.
    task automatic step(input logic r,
                        input logic vi4, input logic [3:0] ai4, input logic [3:0] bi4,
                        input logic vi8, input logic [7:0] ai8, input logic [7:0] bi8);
        logic [1:0] e;
        rst = r;
        v4 = vi4; a4 = ai4; b4 = bi4;
        v8 = vi8; a8 = ai8; b8 = bi8;
        if (r) begin
            mv4 = 1'b0; mg4 = 1'b0; me4 = 1'b0;
            mv8 = 1'b0; mg8 = 1'b0; me8 = 1'b0;
        end else begin
            mv4 = vi4;
            mv8 = vi8;
            if (vi4) q4.push_back({ref_gt4(ai4, bi4), ai4 == bi4});
            if (vi8) q8.push_back({ref_gt8(ai8, bi8), ai8 == bi8});
        end
        @(posedge clk);
        #1;
        check("valid_out4", {31'd0, vo4}, {31'd0, mv4});
        if ((vo4 || mv4) && q4.size() != 0) begin
            e = q4.pop_front();
            mg4 = e[1];
            me4 = e[0];
        end
        check("gt4", {31'd0, gt4}, {31'd0, mg4});
        check("eq4", {31'd0, eq4}, {31'd0, me4});
        check("excl4", {31'd0, gt4 & eq4}, 32'd0);

        check("valid_out8", {31'd0, vo8}, {31'd0, mv8});
        if ((vo8 || mv8) && q8.size() != 0) begin
            e = q8.pop_front();
            mg8 = e[1];
            me8 = e[0];
        end
        check("gt8", {31'd0, gt8}, {31'd0, mg8});
        check("eq8", {31'd0, eq8}, {31'd0, me8});
        check("excl8", {31'd0, gt8 & eq8}, 32'd0);
        @(negedge clk);
    endtask

    logic [3:0] dir_a4[8] = '{4'h0, 4'h1, 4'h0, 4'hF, 4'hF, 4'h8, 4'h0, 4'hE};
    logic [3:0] dir_b4[8] = '{4'h0, 4'h0, 4'h1, 4'h0, 4'hF, 4'h2, 4'hF, 4'hE};
    logic [1:0] dir_e4[8] = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b01};
    logic [7:0] dir_a8[4] = '{8'h7F, 8'h80, 8'h80, 8'hFF};
    logic [7:0] dir_b8[4] = '{8'h80, 8'h7F, 8'h80, 8'hFE};
    logic [1:0] dir_e8[4] = '{2'b10, 2'b00, 2'b01, 2'b10};

    initial begin
        logic [7:0] ab;
        @(negedge clk);

        // Reset held two cycles, then one idle cycle
        step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 8'h00);
        step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 8'h00);
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 8'h00);
        check("rst_gt4", {31'd0, gt4}, 32'd0);
        check("rst_eq4", {31'd0, eq4}, 32'd0);

        // Directed back-to-back pairs, constants cross-checked against table
        for (int i = 0; i < 8; i++) begin
            if (i < 4)
                step(1'b0, 1'b1, dir_a4[i], dir_b4[i], 1'b1, dir_a8[i], dir_b8[i]);
            else
                step(1'b0, 1'b1, dir_a4[i], dir_b4[i], 1'b0, 8'h00, 8'h00);
            check("dir4", {30'd0, gt4, eq4}, {30'd0, dir_e4[i]});
            if (i < 4) check("dir8", {30'd0, gt8, eq8}, {30'd0, dir_e8[i]});
        end

        // Hold: flags keep last result while valid_in is low
        step(1'b0, 1'b1, 4'h1, 4'h0, 1'b0, 8'h00, 8'h00);
        step(1'b0, 1'b0, 4'h0, 4'h1, 1'b0, 8'h00, 8'h00);
        check("hold_vo4", {31'd0, vo4}, 32'd0);
        check("hold_gt4", {31'd0, gt4}, 32'd1);
        check("hold_eq4", {31'd0, eq4}, 32'd0);

        // Reset on the same edge as a valid pair discards it
        step(1'b0, 1'b1, 4'h1, 4'h0, 1'b1, 8'h7F, 8'h80);
        step(1'b1, 1'b1, 4'h1, 4'h0, 1'b1, 8'h7F, 8'h80);
        check("rstmid_vo4", {31'd0, vo4}, 32'd0);
        check("rstmid_gt4", {31'd0, gt4}, 32'd0);
        check("rstmid_gt8", {31'd0, gt8}, 32'd0);

        // Exhaustive SIZE=4 sweep, random SIZE=8 pairs alongside
        for (int i = 0; i < 256; i++) begin
            ab = i[7:0];
            step(1'b0, 1'b1, ab[7:4], ab[3:0], 1'b1,
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 8'h00);

        check("sb4_drained", q4.size(), 32'd0);
        check("sb8_drained", q8.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
